// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game engine: state encoding, widths and the
// pad-index to lamp-mask helper.
package simon_pkg;

    localparam int unsigned MAX_PADS = 8;
    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_PAUSE    = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    function automatic logic [MAX_PADS-1:0] pad_onehot(input int unsigned idx);
        return MAX_PADS'(1) << idx;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,15,13,4) folded into a pad index
// in the range 0..NUM_PADS-1.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter int unsigned       NUM_PADS = 4,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [$clog2(NUM_PADS)-1:0] idx
);

    localparam int unsigned IW = $clog2(NUM_PADS);

    logic [LFSR_W-1:0] q;
    logic [IW-1:0]     raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[14] ^ q[12] ^ q[3]};
        end
    end

    // A single subtraction suffices: raw < 2*NUM_PADS for any pad count.
    assign raw = q[IW-1:0];
    assign idx = (32'(raw) >= NUM_PADS) ? raw - IW'(NUM_PADS) : raw;

endmodule

// File: rtl/simon_engine.sv
// Simon game engine: grows a random pad sequence, replays it on the lamps,
// checks the player's presses and keeps score and high score.
module simon_engine
    import simon_pkg::*;
#(
    parameter int unsigned       NUM_PADS  = 4,
    parameter int unsigned       MAX_LEN   = 16,
    parameter int unsigned       SLOW_ON   = 50_000_000,
    parameter int unsigned       SLOW_OFF  = 10_000_000,
    parameter int unsigned       FAST_ON   = 20_000_000,
    parameter int unsigned       FAST_OFF  = 5_000_000,
    parameter int unsigned       TIMEOUT   = 300_000_000,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           speed_sel,
    input  logic [$clog2(MAX_LEN+1)-1:0]   target_len,
    input  logic [NUM_PADS-1:0]            pad_in,
    output logic [NUM_PADS-1:0]            pad_out,
    output logic [STATE_W-1:0]             state,
    output logic [$clog2(MAX_LEN+1)-1:0]   score,
    output logic [$clog2(MAX_LEN+1)-1:0]   high_score,
    output logic                           win,
    output logic                           lose
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = $clog2(NUM_PADS);
    localparam int unsigned AW = $clog2(MAX_LEN);

    state_t            st;
    logic [NUM_PADS-1:0] pad_in_q;
    logic [NUM_PADS-1:0] press;
    logic              start_q;
    logic              start_rise;
    logic              speed;
    logic [LW-1:0]     target;
    logic [LW-1:0]     len;
    logic [LW-1:0]     pos;
    logic [31:0]       cnt;
    logic [31:0]       timer;
    logic              blink;

    logic [IW-1:0]     seq [MAX_LEN];
    logic [IW-1:0]     seq_rd;
    logic              seq_we;
    logic [AW-1:0]     seq_waddr;
    logic [IW-1:0]     lfsr_idx;

    logic [31:0]       on_cycles;
    logic [31:0]       off_cycles;
    logic [NUM_PADS-1:0] expected;
    logic              any_press;
    logic              hit;
    logic              last;
    logic [LW-1:0]     target_eff;
    logic [LW-1:0]     score_inc;
    logic [LW-1:0]     high_win;
    logic [LW-1:0]     high_lose;

    simon_lfsr #(
        .NUM_PADS (NUM_PADS),
        .SEED     (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (lfsr_idx)
    );

    // Edge detectors are registered, so a press is seen one cycle after the rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_in_q   <= '0;
            press      <= '0;
            start_q    <= 1'b0;
            start_rise <= 1'b0;
        end else begin
            pad_in_q   <= pad_in;
            press      <= pad_in & ~pad_in_q;
            start_q    <= start;
            start_rise <= start & ~start_q;
        end
    end

    assign on_cycles  = speed ? SLOW_ON  : FAST_ON;
    assign off_cycles = speed ? SLOW_OFF : FAST_OFF;
    assign seq_rd     = seq[pos[AW-1:0]];
    assign expected   = NUM_PADS'(pad_onehot(32'(seq_rd)));
    assign any_press  = |press;
    assign hit        = (press == expected);
    assign last       = (pos == len - LW'(1));
    assign target_eff = (target_len == '0 || 32'(target_len) > MAX_LEN) ? LW'(MAX_LEN) : target_len;
    assign score_inc  = (32'(score) >= MAX_LEN) ? score : score + LW'(1);
    assign high_win   = (score_inc > high_score) ? score_inc : high_score;
    assign high_lose  = (score > high_score) ? score : high_score;
    assign state      = st;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        seq_we    = 1'b0;
        seq_waddr = '0;
        if (st == S_IDLE && start_rise) begin
            seq_we = 1'b1;
        end else if (st == S_INPUT && any_press && hit && last && len != target) begin
            seq_we    = 1'b1;
            seq_waddr = len[AW-1:0];
        end
    end

    // NOTE: the sequence store has no reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq[seq_waddr] <= lfsr_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            pad_out    <= '0;
            score      <= '0;
            high_score <= '0;
            win        <= 1'b0;
            lose       <= 1'b0;
            speed      <= 1'b0;
            target     <= '0;
            len        <= '0;
            pos        <= '0;
            cnt        <= '0;
            timer      <= '0;
            blink      <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here; a later assignment in the case overrides them.
            win  <= 1'b0;
            lose <= 1'b0;
            case (st)
                S_IDLE: begin
                    pad_out <= '0;
                    if (start_rise) begin
                        speed  <= speed_sel;
                        target <= target_eff;
                        len    <= LW'(1);
                        pos    <= '0;
                        score  <= '0;
                        cnt    <= '0;
                        st     <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    pad_out <= '0;
                    if (cnt == off_cycles - 32'd1) begin
                        cnt <= '0;
                        pos <= '0;
                        st  <= S_SHOW_ON;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_SHOW_ON: begin
                    pad_out <= expected;
                    if (cnt == on_cycles - 32'd1) begin
                        cnt <= '0;
                        st  <= S_SHOW_OFF;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_SHOW_OFF: begin
                    pad_out <= '0;
                    if (cnt == off_cycles - 32'd1) begin
                        cnt <= '0;
                        if (last) begin
                            pos   <= '0;
                            timer <= '0;
                            st    <= S_INPUT;
                        end else begin
                            pos <= pos + LW'(1);
                            st  <= S_SHOW_ON;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_INPUT: begin
                    pad_out <= pad_in;
                    // A press in the timeout cycle is evaluated first and wins.
                    if (any_press) begin
                        if (hit) begin
                            timer <= '0;
                            if (!last) begin
                                pos <= pos + LW'(1);
                            end else begin
                                score <= score_inc;
                                if (len == target) begin
                                    high_score <= high_win;
                                    win        <= 1'b1;
                                    st         <= S_WIN;
                                end else begin
                                    len <= len + LW'(1);
                                    cnt <= '0;
                                    st  <= S_PAUSE;
                                end
                            end
                        end else begin
                            high_score <= high_lose;
                            lose       <= 1'b1;
                            cnt        <= '0;
                            blink      <= 1'b1;
                            st         <= S_LOSE;
                        end
                    end else if (timer == TIMEOUT - 32'd1) begin
                        high_score <= high_lose;
                        lose       <= 1'b1;
                        cnt        <= '0;
                        blink      <= 1'b1;
                        st         <= S_LOSE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_WIN: begin
                    pad_out <= '1;
                    if (start_rise) begin
                        st <= S_IDLE;
                    end
                end
                S_LOSE: begin
                    pad_out <= {NUM_PADS{blink}};
                    if (cnt == off_cycles - 32'd1) begin
                        cnt   <= '0;
                        blink <= ~blink;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                    if (start_rise) begin
                        st <= S_IDLE;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_engine.sv
// Self-checking bench for simon_engine: learns the replayed sequence from the
// lamps, plays games against it and checks scoring, timing and abort behaviour.
module tb_simon_engine;

    localparam int NP      = 4;
    localparam int ML      = 4;
    localparam int S_ON    = 4;
    localparam int S_OFF   = 2;
    localparam int F_ON    = 3;
    localparam int F_OFF   = 1;
    localparam int TMO     = 20;

    localparam int ST_IDLE  = 0;
    localparam int ST_PAUSE = 1;
    localparam int ST_SHOW  = 2;
    localparam int ST_INPUT = 4;
    localparam int ST_WIN   = 5;
    localparam int ST_LOSE  = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          speed_sel;
    logic [2:0]    target_len;
    logic [NP-1:0] pad_in;
    logic [NP-1:0] pad_out;
    logic [2:0]    state;
    logic [2:0]    score;
    logic [2:0]    high_score;
    logic          win;
    logic          lose;

    int n_tests = 0;
    int n_fail  = 0;

    int seq_q[$];
    int exp_high;
    int obs_state, obs_win, obs_lose, obs_score, obs_high;

    simon_engine #(
        .NUM_PADS (NP),
        .MAX_LEN  (ML),
        .SLOW_ON  (S_ON),
        .SLOW_OFF (S_OFF),
        .FAST_ON  (F_ON),
        .FAST_OFF (F_OFF),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .speed_sel  (speed_sel),
        .target_len (target_len),
        .pad_in     (pad_in),
        .pad_out    (pad_out),
        .state      (state),
        .score      (score),
        .high_score (high_score),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP-1:0] mask_of(input int idx);
        logic [NP-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    function automatic int idx_of(input logic [NP-1:0] m);
        int r;
        r = -1;
        for (int i = 0; i < NP; i++) if (m[i]) r = i;
        return r;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Starts a fresh game, then scrambles the sampled inputs to show they are held.
    task automatic new_game(input int tgt, input logic spd);
        if (state != 3'(ST_IDLE)) begin
            pulse_start();
            check("to_idle", state, ST_IDLE);
        end
        target_len = 3'(tgt);
        speed_sel  = spd;
        pulse_start();
        check("start_pause", state, ST_PAUSE);
        target_len = 3'($urandom);
        speed_sel  = 1'($urandom);
        seq_q.delete();
    endtask

    // Watches the lamps until INPUT, checking pad shape, lit/dark timing and that
    // the replay extends the previously learned sequence by one pad.
    task automatic watch_replay(input int exp_len, input int on_c, input int off_c);
        int lit_idx[$];
        int lit_len[$];
        int gap_len[$];
        int run, gap, n;
        bit shape_ok, time_ok, pre_ok;
        logic [NP-1:0] prev;
        run = 0; gap = 0; n = 0;
        shape_ok = 1'b1; time_ok = 1'b1; pre_ok = 1'b1;
        prev = '0;
        while (state != 3'(ST_INPUT) && n < 400) begin
            if (pad_out != '0) begin
                if (run == 0) begin
                    if (lit_idx.size() > 0) gap_len.push_back(gap);
                    lit_idx.push_back(idx_of(pad_out));
                    if (!$onehot(pad_out)) shape_ok = 1'b0;
                end else if (pad_out != prev) begin
                    shape_ok = 1'b0;
                end
                run++;
                gap = 0;
            end else begin
                if (run > 0) lit_len.push_back(run);
                run = 0;
                gap++;
            end
            prev = pad_out;
            tick();
            n++;
        end
        check("replay_reaches_input", int'(n < 400), 1);
        check("replay_count", lit_idx.size(), exp_len);
        check("replay_onehot", shape_ok, 1);
        foreach (lit_len[i]) if (lit_len[i] != on_c) time_ok = 1'b0;
        foreach (gap_len[i]) if (gap_len[i] != off_c) time_ok = 1'b0;
        check("replay_timing", time_ok, 1);
        for (int i = 0; i < lit_idx.size() && i < seq_q.size(); i++)
            if (lit_idx[i] != seq_q[i]) pre_ok = 1'b0;
        check("replay_prefix", pre_ok, 1);
        if (lit_idx.size() == exp_len && exp_len == seq_q.size() + 1)
            seq_q.push_back(lit_idx[exp_len-1]);
    endtask

    // Decision lands two edges after pad_in rises; outputs are captured there.
    task automatic press_pad(input logic [NP-1:0] m, input int hold);
        pad_in = m;
        tick();
        tick();
        obs_state = int'(state);
        obs_win   = int'(win);
        obs_lose  = int'(lose);
        obs_score = int'(score);
        obs_high  = int'(high_score);
        repeat (hold) tick();
        pad_in = '0;
        tick();
    endtask

    task automatic play_rounds(input int rounds, input int tgt, input int on_c, input int off_c);
        int hold;
        for (int r = 1; r <= rounds; r++) begin
            watch_replay(r, on_c, off_c);
            for (int i = 0; i < r; i++) begin
                hold = (i == 0 && r > 1) ? int'($urandom_range(1, 3)) : 0;
                press_pad(mask_of(seq_q[i]), hold);
                if (i < r - 1) begin
                    check("mid_press_state", obs_state, ST_INPUT);
                end else if (r < tgt) begin
                    check("round_state", obs_state, ST_PAUSE);
                    check("round_score", obs_score, r);
                end else begin
                    if (r > exp_high) exp_high = r;
                    check("win_state", obs_state, ST_WIN);
                    check("win_pulse", obs_win, 1);
                    check("win_score", obs_score, r);
                    check("win_high", obs_high, exp_high);
                    check("win_pulse_len", win, 0);
                    check("win_lamps", pad_out, 4'hF);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0] s[8];
        logic [NP-1:0] m;
        int c, o, n;
        bit ok;

        rst_n = 1'b0; start = 1'b0; speed_sel = 1'b1; target_len = 3'd3; pad_in = '0;
        exp_high = 0;
        repeat (3) tick();
        check("rst_state", state, ST_IDLE);
        check("rst_pad_out", pad_out, 0);
        check("rst_score", score, 0);
        check("rst_high", high_score, 0);
        check("rst_pulses", {win, lose}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Game 1: three correct rounds to a win.
        new_game(3, 1'b1);
        play_rounds(3, 3, S_ON, S_OFF);

        // Game 2: lose on a wrong pad in round 2.
        new_game(3, 1'b1);
        play_rounds(1, 3, S_ON, S_OFF);
        watch_replay(2, S_ON, S_OFF);
        o = (seq_q[0] + 1 + int'($urandom_range(0, NP - 2))) % NP;
        press_pad(mask_of(o), 0);
        check("wrong_state", obs_state, ST_LOSE);
        check("wrong_pulse", obs_lose, 1);
        check("wrong_score", obs_score, 1);
        check("wrong_high", obs_high, exp_high);
        check("lose_pulse_len", lose, 0);
        for (int i = 0; i < 8; i++) begin
            s[i] = pad_out;
            tick();
        end
        ok = 1'b1;
        for (int i = 0; i < 6; i++) if (s[i+2] != ~s[i]) ok = 1'b0;
        for (int i = 0; i < 8; i++) if (s[i] != '0 && s[i] != '1) ok = 1'b0;
        check("lose_blink", ok, 1);
        check("lose_hold_state", state, ST_LOSE);

        // Game 3: fast mode, no press -> timeout exactly TMO cycles into INPUT.
        new_game(3, 1'b0);
        watch_replay(1, F_ON, F_OFF);
        n = 0;
        while (state != 3'(ST_LOSE) && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TMO);
        check("timeout_pulse", lose, 1);
        check("timeout_high", high_score, exp_high);

        // Game 4: correct pad plus another pad rising together -> lose.
        new_game(3, 1'b1);
        watch_replay(1, S_ON, S_OFF);
        c = seq_q[0];
        o = (c + 1 + int'($urandom_range(0, NP - 2))) % NP;
        m = mask_of(c) | mask_of(o);
        press_pad(m, 0);
        check("multi_state", obs_state, ST_LOSE);
        check("multi_score", obs_score, 0);
        check("multi_high", obs_high, exp_high);

        // Reset in the middle of a replay.
        new_game(3, 1'b1);
        n = 0;
        while (pad_out == '0 && n < 100) begin
            tick();
            n++;
        end
        check("reach_show_on", state, ST_SHOW);
        #2 rst_n = 1'b0;
        #1;
        check("abort_state", state, ST_IDLE);
        check("abort_pad_out", pad_out, 0);
        check("abort_high", high_score, 0);
        check("abort_score", score, 0);
        exp_high = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Game 5: target 0 runs to the full storage depth.
        new_game(0, 1'b1);
        play_rounds(ML, ML, S_ON, S_OFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_engine.md
# simon_engine

Parametrised Simon-game engine: generates a pseudo-random pad sequence, replays it on `pad_out` with selectable speed, checks player presses, and reports win/lose, score and high score. Successor to the fixed 4-pad game core, generalised in pad count, maximum length and timing, with a configurable target length, an input timeout, multi-press rejection and a persistent high score. Sits between the board buttons/LEDs and the VGA/7-segment display logic, which consume `state`, `pad_out` and `score`.

## Interface
- `NUM_PADS`, 4: number of pads/buttons, 2..8.
- `MAX_LEN`, 16: sequence storage depth and maximum target length, 2..32.
- `SLOW_ON`, 50_000_000: pad lit cycles, slow mode.
- `SLOW_OFF`, 10_000_000: dark gap cycles, slow mode.
- `FAST_ON`, 20_000_000: pad lit cycles, fast mode.
- `FAST_OFF`, 5_000_000: dark gap cycles, fast mode.
- `TIMEOUT`, 300_000_000: maximum cycles between presses in INPUT.
- `LFSR_SEED`, 16'hACE1: nonzero LFSR reset value.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; rising edge acts.
- `speed_sel` in 1: 1 = slow, 0 = fast; sampled on start.
- `target_len` in $clog2(MAX_LEN+1): rounds to win; sampled on start.
- `pad_in` in NUM_PADS: raw (already synchronised) buttons, active-high.
- `pad_out` out NUM_PADS: pad lamps.
- `state` out 3: current FSM state (package encoding).
- `score` out $clog2(MAX_LEN+1): completed rounds this game.
- `high_score` out $clog2(MAX_LEN+1): best score since reset.
- `win` out 1, `lose` out 1: single-cycle pulses on entry to WIN/LOSE.

## Operation
- Reset: state IDLE; `pad_out`, `score`, `high_score`, `win`, `lose`, length, position, counters = 0; LFSR = LFSR_SEED.
- Edge detection: `press = pad_in & ~pad_in_q`, registered; one-cycle latency. `start_rise` likewise.
- LFSR: 16-bit Fibonacci, taps 16,15,13,4, advances every cycle. Pad index = low $clog2(NUM_PADS) bits; if ≥ NUM_PADS, subtract NUM_PADS.
- IDLE: `pad_out`=0. On `start_rise`: latch speed, latch target (0 or > MAX_LEN → MAX_LEN), seq[0] = LFSR index, len=1, pos=0, score=0 → PAUSE.
- PAUSE: dark for OFF cycles, then pos=0 → SHOW_ON.
- SHOW_ON: `pad_out` = one-hot(seq[pos]) for ON cycles → SHOW_OFF.
- SHOW_OFF: dark for OFF cycles; if pos == len-1 → INPUT (pos=0, timer=0) else pos+1 → SHOW_ON.
- INPUT: `pad_out` = `pad_in` registered echo. Any cycle with press ≠ 0:
  - press == one-hot(seq[pos]): timer=0; if pos < len-1 pos+1; else score+1 and, if len == target → WIN, otherwise seq[len]=LFSR index, len+1 → PAUSE.
  - any other nonzero press (wrong pad or ≥2 simultaneous edges) → LOSE.
  - timer reaches TIMEOUT with no press → LOSE.
- WIN: `pad_out` all ones. LOSE: `pad_out` toggles all-ones/zero every OFF cycles. Both: on entry, pulse and `high_score` = max(high_score, new score). `start_rise` → IDLE.
- `start_rise` ignored outside IDLE/WIN/LOSE; `speed_sel`/`target_len` changes ignored mid-game.
- `rst_n` low at any time aborts immediately to reset values, including mid-replay.

## Timing
- Each delay counter counts exactly N cycles: SHOW_ON occupies ON cycles, PAUSE/SHOW_OFF OFF cycles.
- `pad_out` is registered; changes the cycle after the state change.
- Press decision occurs in the cycle `press` is valid (2 cycles after `pad_in` rises); state/score update next edge.
- `score` saturates at MAX_LEN; `score` increments in the same cycle as the round-complete transition.
- Timeout and correct press in same cycle: press wins.
- `pad_in` held high produces one press only.

## Structure
- `simon_pkg`: state encoding (IDLE=0, PAUSE=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, WIN=5, LOSE=6), one-hot helper function, width localparams.
- Sub-module `simon_lfsr` (seed parameter, index output mod NUM_PADS).
- Sequence storage: MAX_LEN × $clog2(NUM_PADS) register array, not cleared by reset.

## Test plan
- NUM_PADS=4, ON=4, OFF=2, target=3: echo shown sequence each round → WIN pulse after third round, score=3, high_score=3, `pad_out`=4'b1111.
- Round 2, press wrong pad → LOSE pulse, score=1, `pad_out` blinking period 2.
- INPUT with TIMEOUT=20, no press → LOSE exactly 20 cycles after INPUT entry.
- Two pads rising in the same cycle where one is correct → LOSE.
- Start second game, lose at score 1 → high_score stays 3; reset → high_score 0.
- `rst_n` low during SHOW_ON → `pad_out`=0, state IDLE immediately; target_len=0 → game runs to MAX_LEN.
